// File: rtl/adc_ltc1407a_ctrl_if.sv
// Pin and handshake bundle between user logic, the SPI arbiter, the LTC1407A-1 and its sequencer.
// The master modport is the sequencer's view of the bundle.
interface adc_ltc1407a_ctrl_if;
  logic              start;
  logic              ready;
  logic              spi_req;
  logic              spi_gnt;
  logic              AD_CONV;
  logic              SPI_SCK;
  logic              ADC_OUT;
  logic signed [13:0] ch0;
  logic signed [13:0] ch1;
  logic              valid;

  modport master (
    input  start, spi_gnt, ADC_OUT,
    output ready, spi_req, AD_CONV, SPI_SCK, ch0, ch1, valid
  );

  modport slave (
    output start, spi_gnt, ADC_OUT,
    input  ready, spi_req, AD_CONV, SPI_SCK, ch0, ch1, valid
  );
endinterface

// File: rtl/adc_ltc1407a_ctrl.sv
// LTC1407A-1 sequencer: takes the shared SPI bus, strobes AD_CONV, clocks out 34 SCK periods
// and presents both 14-bit channels as two's-complement samples with a one-cycle valid pulse.
module adc_ltc1407a_ctrl #(
  parameter int SCK_HALF = 2,
  parameter int CONV_LEN = 2,
  parameter int LOGLEVEL = 5
) (
  input logic                CLK,
  input logic                RST,
  adc_ltc1407a_ctrl_if.master bus
);

  localparam int CMAX = (SCK_HALF > CONV_LEN) ? SCK_HALF : CONV_LEN;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SCK_LAST  = CW'(SCK_HALF - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_LEN - 1);

  if (SCK_HALF < 1 || CONV_LEN < 1 || LOGLEVEL < 0) begin : g_param_check
    $error("adc_ltc1407a_ctrl: SCK_HALF and CONV_LEN must be >= 1, LOGLEVEL >= 0");
  end

  typedef enum logic [2:0] {IDLE, REQ, CONV, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [5:0]         bit_q, bit_d;
  logic [33:0]        sr_q, sr_d;
  logic               ready_q, ready_d;
  logic               req_q, req_d;
  logic               conv_q, conv_d;
  logic               sck_q, sck_d;
  logic signed [13:0] ch0_q, ch0_d;
  logic signed [13:0] ch1_q, ch1_d;
  logic               valid_q, valid_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      ready_q <= 1'b1;
      req_q   <= 1'b0;
      conv_q  <= 1'b0;
      sck_q   <= 1'b0;
      ch0_q   <= '0;
      ch1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      conv_q  <= conv_d;
      sck_q   <= sck_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    ready_d = ready_q;
    req_d   = req_q;
    conv_d  = conv_q;
    sck_d   = sck_q;
    ch0_d   = ch0_q;
    ch1_d   = ch1_q;
    valid_d = 1'b0;

    // Losing the grant mid-transfer abandons the frame; the samples keep their old values.
    if ((state_q == CONV || state_q == SHIFT) && !bus.spi_gnt) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      ready_d = 1'b1;
      req_d   = 1'b0;
      conv_d  = 1'b0;
      sck_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          state_d = REQ;
          req_d   = 1'b1;
          ready_d = 1'b0;
        end
        REQ: if (bus.spi_gnt) begin
          state_d = CONV;
          conv_d  = 1'b1;
          cnt_d   = '0;
        end
        CONV: if (cnt_q == CONV_LAST) begin
          state_d = SHIFT;
          conv_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        SHIFT: if (cnt_q == SCK_LAST) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          // Sample on the rising SCK edge; the bit counter advances on each falling edge.
          if (!sck_q) begin
            sr_d = {sr_q[32:0], bus.ADC_OUT};
          end else if (bit_q == 6'd33) begin
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        DONE: begin
          ch0_d   = $signed(sr_q[31:18]);
          ch1_d   = $signed(sr_q[15:2]);
          valid_d = 1'b1;
          req_d   = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.spi_req = req_q;
  assign bus.AD_CONV = conv_q;
  assign bus.SPI_SCK = sck_q;
  assign bus.ch0     = ch0_q;
  assign bus.ch1     = ch1_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_adc_ltc1407a_ctrl.sv
// Bench for adc_ltc1407a_ctrl: two instances (default timing and SCK_HALF=1/CONV_LEN=1), an ADC pin
// model fed from a frame queue, and per-instance scoreboards checked whenever valid is seen.
module tb_adc_ltc1407a_ctrl;

  typedef struct {
    logic [13:0] c0;
    logic [13:0] c1;
    int          at;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  int   total = 0;
  int   bad   = 0;
  logic start_s [2];
  logic gnt_s   [2];
  int   lat     [2];
  logic [13:0] last0 [2];
  logic [13:0] last1 [2];
  exp_t        exp_q [2][$];
  logic [33:0] adc_q [2][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int SHP = (g == 0) ? 2 : 1;
    localparam int CLP = (g == 0) ? 2 : 1;

    adc_ltc1407a_ctrl_if ifc ();
    adc_ltc1407a_ctrl #(.SCK_HALF(SHP), .CONV_LEN(CLP), .LOGLEVEL(0)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(ifc.master)
    );

    logic [33:0] frame     = '0;
    int          idx       = 0;
    int          sck_n     = 0;
    int          conv_len  = 0;
    logic        prev_conv = 1'b0;
    logic        prev_vld  = 1'b0;

    assign ifc.start   = start_s[g];
    assign ifc.spi_gnt = gnt_s[g];
    assign ifc.ADC_OUT = frame[6'(33 - idx)];

    // ADC pin model: frame loaded at AD_CONV rise, next bit presented on every SCK fall.
    initial forever begin
      @(posedge ifc.AD_CONV or edge ifc.SPI_SCK);
      if (ifc.AD_CONV) begin
        frame = (adc_q[g].size() > 0) ? adc_q[g].pop_front() : 34'({$urandom(), $urandom()});
        idx   = 0;
        sck_n = 0;
      end else if (ifc.SPI_SCK) begin
        sck_n++;
      end else if (idx < 33) begin
        idx++;
      end
    end

    initial forever begin
      exp_t e;
      @(negedge CLK);
      if (ifc.AD_CONV) conv_len = prev_conv ? conv_len + 1 : 1;
      prev_conv = ifc.AD_CONV;
      if (ifc.valid) begin
        chk($sformatf("u%0d_valid_width", g), 32'(prev_vld), 32'd0);
        if (exp_q[g].size() == 0) begin
          total++;
          bad++;
          $display("FAIL u%0d_unexpected_valid: got valid expected none (cyc %0d)", g, cyc);
        end else begin
          e = exp_q[g].pop_front();
          chk($sformatf("u%0d_ch0", g), 32'($unsigned(ifc.ch0)), 32'(e.c0));
          chk($sformatf("u%0d_ch1", g), 32'($unsigned(ifc.ch1)), 32'(e.c1));
          chk($sformatf("u%0d_latency_cyc", g), 32'(cyc), 32'(e.at));
          chk($sformatf("u%0d_sck_rises", g), 32'(sck_n), 32'd34);
          chk($sformatf("u%0d_conv_len", g), 32'(conv_len), 32'(CLP));
          chk($sformatf("u%0d_ready_at_valid", g), 32'(ifc.ready), 32'd1);
        end
      end
      prev_vld = ifc.valid;
    end
  end

  task automatic conv(input int g, input logic [13:0] a, input logic [13:0] b,
                      input bit expv, input int extra);
    @(negedge CLK);
    adc_q[g].push_back({2'($urandom()), a, 2'($urandom()), b, 2'($urandom())});
    if (expv) begin
      exp_q[g].push_back(exp_t'{a, b, cyc + 1 + lat[g] + extra});
      last0[g] = a;
      last1[g] = b;
    end
    start_s[g] = 1'b1;
    @(negedge CLK);
    start_s[g] = 1'b0;
  endtask

  task automatic drain(input int g, input int budget);
    for (int i = 0; i < budget && exp_q[g].size() != 0; i++) @(negedge CLK);
    chk($sformatf("u%0d_pending_after_wait", g), 32'(exp_q[g].size()), 32'd0);
    exp_q[g].delete();
    repeat (3) @(negedge CLK);
  endtask

  task automatic chk_rst(input string nm, input logic r, input logic q, input logic c,
                         input logic s, input logic v, input logic [13:0] a, input logic [13:0] b);
    chk({nm, "_ready"}, 32'(r), 32'd1);
    chk({nm, "_spi_req"}, 32'(q), 32'd0);
    chk({nm, "_ad_conv"}, 32'(c), 32'd0);
    chk({nm, "_sck"}, 32'(s), 32'd0);
    chk({nm, "_valid"}, 32'(v), 32'd0);
    chk({nm, "_ch0"}, 32'(a), 32'd0);
    chk({nm, "_ch1"}, 32'(b), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion (cyc %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] ta [4];
    logic [13:0] tb [4];
    bit ok;
    int s0;
    lat[0] = 1 + 2 + 68 * 2 + 1;
    lat[1] = 1 + 1 + 68 * 1 + 1;
    start_s = '{1'b0, 1'b0};
    gnt_s   = '{1'b1, 1'b1};
    last0   = '{14'd0, 14'd0};
    last1   = '{14'd0, 14'd0};

    // Reset state while RST is held
    repeat (3) @(negedge CLK);
    chk_rst("por_u0", u[0].ifc.ready, u[0].ifc.spi_req, u[0].ifc.AD_CONV, u[0].ifc.SPI_SCK,
            u[0].ifc.valid, u[0].ifc.ch0, u[0].ifc.ch1);
    chk_rst("por_u1", u[1].ifc.ready, u[1].ifc.spi_req, u[1].ifc.AD_CONV, u[1].ifc.SPI_SCK,
            u[1].ifc.valid, u[1].ifc.ch0, u[1].ifc.ch1);
    RST = 1'b0;
    @(negedge CLK);

    // Nominal frame, then random frames
    conv(0, 14'h1ABC, 14'h2001, 1'b1, 0);
    drain(0, 400);
    for (int k = 0; k < 3; k++) begin
      conv(0, 14'($urandom()), 14'($urandom()), 1'b1, 0);
      drain(0, 400);
    end

    // Grant held off for 10 cycles
    gnt_s[0] = 1'b0;
    conv(0, 14'($urandom()), 14'($urandom()), 1'b1, 10);
    ok = 1'b1;
    repeat (10) begin
      if (u[0].ifc.AD_CONV || u[0].ifc.SPI_SCK || !u[0].ifc.spi_req || u[0].ifc.ready) ok = 1'b0;
      @(negedge CLK);
    end
    chk("arb_wait_idle_pins", 32'(ok), 32'd1);
    gnt_s[0] = 1'b1;
    drain(0, 400);

    // Grant lost after the 20th SCK rise
    conv(0, 14'($urandom()), 14'($urandom()), 1'b0, 0);
    @(negedge CLK);
    for (int i = 0; i < 400 && u[0].sck_n < 20; i++) @(negedge CLK);
    chk("gloss_sck20", 32'(u[0].sck_n), 32'd20);
    gnt_s[0] = 1'b0;
    @(negedge CLK);
    chk("gloss_spi_req", 32'(u[0].ifc.spi_req), 32'd0);
    chk("gloss_ad_conv", 32'(u[0].ifc.AD_CONV), 32'd0);
    chk("gloss_sck", 32'(u[0].ifc.SPI_SCK), 32'd0);
    chk("gloss_ready", 32'(u[0].ifc.ready), 32'd1);
    repeat (200) @(negedge CLK);
    chk("gloss_ch0_hold", 32'($unsigned(u[0].ifc.ch0)), 32'(last0[0]));
    chk("gloss_ch1_hold", 32'($unsigned(u[0].ifc.ch1)), 32'(last1[0]));
    gnt_s[0] = 1'b1;

    // Asynchronous reset in the middle of SHIFT
    conv(0, 14'($urandom()), 14'($urandom()), 1'b0, 0);
    @(negedge CLK);
    for (int i = 0; i < 400 && u[0].sck_n < 5; i++) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_rst("midrst_u0", u[0].ifc.ready, u[0].ifc.spi_req, u[0].ifc.AD_CONV, u[0].ifc.SPI_SCK,
               u[0].ifc.valid, u[0].ifc.ch0, u[0].ifc.ch1);
    @(negedge CLK);
    RST = 1'b0;
    last0[0] = '0;
    last1[0] = '0;
    @(negedge CLK);
    chk("midrst_ready_after", 32'(u[0].ifc.ready), 32'd1);

    // start held high: back-to-back frames
    @(negedge CLK);
    s0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      ta[k] = 14'($urandom());
      tb[k] = 14'($urandom());
      adc_q[0].push_back({2'($urandom()), ta[k], 2'($urandom()), tb[k], 2'($urandom())});
      exp_q[0].push_back(exp_t'{ta[k], tb[k], s0 + k * (lat[0] + 1) + lat[0]});
    end
    start_s[0] = 1'b1;
    while (cyc < s0 + 2 * (lat[0] + 1) + lat[0]) @(negedge CLK);
    start_s[0] = 1'b0;
    drain(0, 600);

    // Extremes on the fast instance
    ta = '{14'h2000, 14'h1FFF, 14'h0000, 14'h3FFF};
    tb = '{14'h1FFF, 14'h2000, 14'h3FFF, 14'h0000};
    for (int k = 0; k < 4; k++) begin
      conv(1, ta[k], tb[k], 1'b1, 0);
      drain(1, 300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
